// File: rtl/iserdes_pkg.sv
// Shared definitions for the ISERDES frame aligner.
//   - align_state_e : training / lock FSM state encoding
//   - interleave2   : bit-interleave two lane words into one sample word
//   - FramePatDefault : frame-lane word seen when word alignment is correct
package iserdes_pkg;

    // Widest lane word interleave2 can handle; callers pass their real width.
    localparam int unsigned MaxDw = 32;

    localparam logic [7:0] FramePatDefault = 8'hF0;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StSlip,
        StSettle,
        StVerify,
        StLocked,
        StFail
    } align_state_e;

    // Result bit 2*i+1 carries a[i], bit 2*i carries b[i]; bits above 2*dw are 0.
    function automatic logic [2*MaxDw-1:0] interleave2(input logic [MaxDw-1:0] a,
                                                       input logic [MaxDw-1:0] b,
                                                       input int unsigned      dw);
        logic [2*MaxDw-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < MaxDw; i++) begin
            if (i < dw) begin
                w[2*i+1] = a[i];
                w[2*i]   = b[i];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/iserdes_lane_interleave.sv
// One ADC channel: polarity-correct lane A and lane B, bit-interleave them and register
// the result.
//   clkdiv  : divided fabric clock
//   reset   : asynchronous active-high reset, clears dout
//   lane_a  : lane A word (DW bits)
//   lane_b  : lane B word (DW bits)
//   inv_a   : invert lane A, sampled together with the lane data
//   inv_b   : invert lane B, sampled together with the lane data
//   dout    : registered {a[DW-1],b[DW-1],...,a[0],b[0]}
module iserdes_lane_interleave
    import iserdes_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic            clkdiv,
    input  logic            reset,
    input  logic [DW-1:0]   lane_a,
    input  logic [DW-1:0]   lane_b,
    input  logic            inv_a,
    input  logic            inv_b,
    output logic [2*DW-1:0] dout
);

    logic [MaxDw-1:0]   a_ext;
    logic [MaxDw-1:0]   b_ext;
    logic [2*MaxDw-1:0] word;
    logic [2*DW-1:0]    dout_d;
    logic [2*DW-1:0]    dout_q;
    logic               unused_word;

    always_comb begin
        a_ext  = MaxDw'(lane_a ^ {DW{inv_a}});
        b_ext  = MaxDw'(lane_b ^ {DW{inv_b}});
        word   = interleave2(a_ext, b_ext, DW);
        dout_d = word[2*DW-1:0];
    end

    // Upper bits of word are always zero for DW < MaxDw.
    assign unused_word = ^word;

    always_ff @(posedge clkdiv or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/iserdes_frame_align.sv
// Word aligner for NCH 2-lane LVDS ADC channels behind ISERDES deserializers.
// Pulses bitslip until the frame lane shows FRAME_PAT, confirms the match MATCH_CNT times,
// then holds lock until MISS_LIMIT consecutive frame misses. Sample words are emitted every
// cycle; dout_valid qualifies them while locked.
//   clkdiv     : divided fabric clock
//   reset      : asynchronous active-high reset
//   train      : 1 = run/keep alignment, 0 = return to idle
//   frame      : deserialized frame-lane word
//   lane_a/b   : per-channel lane words, channel c at [c*DW +: DW]
//   inv_a/b    : per-channel lane polarity invert
//   bitslip    : one-cycle pulse to every ISERDES BITSLIP input
//   dout       : channel c at [c*2*DW +: 2*DW]
//   dout_valid : dout qualifier, follows locked
//   locked     : frame alignment held
//   slip_cnt   : bitslips issued in the current training run
//   align_err  : training ran out of slip positions without lock
module iserdes_frame_align
    import iserdes_pkg::*;
#(
    parameter int unsigned   NCH        = 2,
    parameter int unsigned   DW         = 8,
    parameter logic [DW-1:0] FRAME_PAT  = DW'(FramePatDefault),
    parameter int unsigned   SLIP_WAIT  = 3,
    parameter int unsigned   MATCH_CNT  = 16,
    parameter int unsigned   MISS_LIMIT = 4,
    localparam int unsigned  SlipW      = $clog2(2*DW) + 1
) (
    input  logic                clkdiv,
    input  logic                reset,
    input  logic                train,
    input  logic [DW-1:0]       frame,
    input  logic [NCH*DW-1:0]   lane_a,
    input  logic [NCH*DW-1:0]   lane_b,
    input  logic [NCH-1:0]      inv_a,
    input  logic [NCH-1:0]      inv_b,
    output logic                bitslip,
    output logic [NCH*2*DW-1:0] dout,
    output logic                dout_valid,
    output logic                locked,
    output logic [SlipW-1:0]    slip_cnt,
    output logic                align_err
);

    localparam int unsigned SettleW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
    localparam int unsigned MatchW  = $clog2(MATCH_CNT + 1);
    localparam int unsigned MissW   = $clog2(MISS_LIMIT + 1);

    align_state_e       state_d,     state_q;
    logic [SlipW-1:0]   slip_cnt_d,  slip_cnt_q;
    logic [SettleW-1:0] settle_d,    settle_q;
    logic [MatchW-1:0]  match_d,     match_q;
    logic [MissW-1:0]   miss_d,      miss_q;
    logic               bitslip_d,   bitslip_q;
    logic               align_err_d, align_err_q;
    logic               locked_d,    locked_q;
    logic               frame_ok;

    always_comb begin
        state_d     = state_q;
        slip_cnt_d  = slip_cnt_q;
        settle_d    = settle_q;
        match_d     = match_q;
        miss_d      = miss_q;
        align_err_d = align_err_q;
        frame_ok    = (frame == FRAME_PAT);

        if (!train) begin
            // slip_cnt and align_err stay visible while idle.
            state_d  = StIdle;
            settle_d = '0;
            match_d  = '0;
            miss_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d     = StCheck;
                    slip_cnt_d  = '0;
                    align_err_d = 1'b0;
                end
                StCheck: begin
                    if (frame_ok) begin
                        state_d = StVerify;
                        match_d = MatchW'(1);
                    end else begin
                        state_d    = StSlip;
                        slip_cnt_d = slip_cnt_q + SlipW'(1);
                    end
                end
                StSlip: begin
                    settle_d = '0;
                    if (slip_cnt_q == SlipW'(2*DW)) begin
                        state_d     = StFail;
                        align_err_d = 1'b1;
                    end else begin
                        state_d = StSettle;
                    end
                end
                StSettle: begin
                    // Frame is not trusted until the ISERDES has finished shifting.
                    if (settle_q == SettleW'(SLIP_WAIT - 1)) begin
                        state_d = StCheck;
                    end else begin
                        settle_d = settle_q + SettleW'(1);
                    end
                end
                StVerify: begin
                    if (frame_ok) begin
                        if (match_q == MatchW'(MATCH_CNT - 1)) begin
                            state_d = StLocked;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + MatchW'(1);
                        end
                    end else begin
                        state_d    = StSlip;
                        match_d    = '0;
                        slip_cnt_d = slip_cnt_q + SlipW'(1);
                    end
                end
                StLocked: begin
                    if (frame_ok) begin
                        miss_d = '0;
                    end else if (miss_q == MissW'(MISS_LIMIT - 1)) begin
                        state_d    = StCheck;
                        miss_d     = '0;
                        slip_cnt_d = '0;
                    end else begin
                        miss_d = miss_q + MissW'(1);
                    end
                end
                StFail: begin
                    state_d = StFail;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Registered outputs: bitslip is high exactly while the FSM sits in StSlip.
        bitslip_d = (state_d == StSlip);
        // locked trails entry into StLocked by one cycle, and drops one cycle after lock is
        // lost, but drops at once when train is withdrawn.
        locked_d  = train && (state_q == StLocked);
    end

    always_ff @(posedge clkdiv or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            slip_cnt_q  <= '0;
            settle_q    <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            bitslip_q   <= 1'b0;
            align_err_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            slip_cnt_q  <= slip_cnt_d;
            settle_q    <= settle_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            bitslip_q   <= bitslip_d;
            align_err_q <= align_err_d;
            locked_q    <= locked_d;
        end
    end

    assign bitslip    = bitslip_q;
    assign slip_cnt   = slip_cnt_q;
    assign align_err  = align_err_q;
    assign locked     = locked_q;
    assign dout_valid = locked_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        iserdes_lane_interleave #(
            .DW(DW)
        ) u_lane (
            .clkdiv(clkdiv),
            .reset (reset),
            .lane_a(lane_a[c*DW +: DW]),
            .lane_b(lane_b[c*DW +: DW]),
            .inv_a (inv_a[c]),
            .inv_b (inv_b[c]),
            .dout  (dout[c*2*DW +: 2*DW])
        );
    end

endmodule

// File: tb/tb_iserdes_frame_align.sv
// Bench for iserdes_frame_align: random lane data checked by a dout scoreboard, an ISERDES
// frame-lane model that rotates left by one bit per bitslip pulse, and directed training,
// loss-of-frame, failure and async-reset scenarios.
module tb_iserdes_frame_align;

    localparam int NCH        = 2;
    localparam int DW         = 8;
    localparam int SLIP_WAIT  = 3;
    localparam int MATCH_CNT  = 16;
    localparam int MISS_LIMIT = 4;
    localparam int SW         = $clog2(2*DW) + 1;
    localparam int LW         = NCH * DW;
    localparam logic [DW-1:0] PAT = 8'hF0;

    logic                clkdiv = 1'b0;
    logic                reset  = 1'b1;
    logic                train  = 1'b0;
    logic [DW-1:0]       frame;
    logic [LW-1:0]       lane_a = '0;
    logic [LW-1:0]       lane_b = '0;
    logic [NCH-1:0]      inv_a  = '0;
    logic [NCH-1:0]      inv_b  = '0;
    logic                bitslip;
    logic [NCH*2*DW-1:0] dout;
    logic                dout_valid;
    logic                locked;
    logic [SW-1:0]       slip_cnt;
    logic                align_err;

    int checks = 0;
    int errors = 0;

    logic [NCH*2*DW-1:0] exp_q[$];

    // Link model: frame lane is frame_start rotated left once per observed bitslip pulse.
    int            pulse_cnt      = 0;  // written by the monitor only
    int            pulse_base     = 0;
    logic [DW-1:0] frame_start    = PAT;
    logic          frame_force_en = 1'b1;
    logic [DW-1:0] frame_force    = PAT;
    logic          lane_fixed     = 1'b0;

    logic [NCH*2*DW-1:0] mon_exp;
    bit                  mon_have;
    int                  mon_cyc  = 0;
    int                  mon_last = -1;

    always #5 clkdiv = ~clkdiv;

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] x, input int n);
        logic [DW-1:0] r;
        r = x;
        for (int i = 0; i < n % DW; i++) r = {r[DW-2:0], r[DW-1]};
        return r;
    endfunction

    function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x, input int n);
        return rotl(x, DW - (n % DW));
    endfunction

    assign frame = frame_force_en ? frame_force : rotl(frame_start, pulse_cnt - pulse_base);

    function automatic logic [NCH*2*DW-1:0] model_dout(input logic [LW-1:0]  a,
                                                       input logic [LW-1:0]  b,
                                                       input logic [NCH-1:0] ia,
                                                       input logic [NCH-1:0] ib);
        logic [NCH*2*DW-1:0] w;
        w = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < DW; i++) begin
                w[c*2*DW + 2*i + 1] = a[c*DW + i] ^ ia[c];
                w[c*2*DW + 2*i]     = b[c*DW + i] ^ ib[c];
            end
        end
        return w;
    endfunction

    iserdes_frame_align #(
        .NCH       (NCH),
        .DW        (DW),
        .FRAME_PAT (PAT),
        .SLIP_WAIT (SLIP_WAIT),
        .MATCH_CNT (MATCH_CNT),
        .MISS_LIMIT(MISS_LIMIT)
    ) dut (
        .clkdiv    (clkdiv),
        .reset     (reset),
        .train     (train),
        .frame     (frame),
        .lane_a    (lane_a),
        .lane_b    (lane_b),
        .inv_a     (inv_a),
        .inv_b     (inv_b),
        .bitslip   (bitslip),
        .dout      (dout),
        .dout_valid(dout_valid),
        .locked    (locked),
        .slip_cnt  (slip_cnt),
        .align_err (align_err)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Lane values set here are captured by the next rising edge; returns 1 unit after it.
    task automatic cycle();
        if (!lane_fixed) begin
            lane_a = LW'($urandom);
            lane_b = LW'($urandom);
            inv_a  = NCH'($urandom);
            inv_b  = NCH'($urandom);
        end
        if (!reset) exp_q.push_back(model_dout(lane_a, lane_b, inv_a, inv_b));
        @(posedge clkdiv);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_locked"},     locked,     0);
        check({tag, "_dout_valid"}, dout_valid, 0);
        check({tag, "_bitslip"},    bitslip,    0);
        check({tag, "_slip_cnt"},   slip_cnt,   0);
        check({tag, "_align_err"},  align_err,  0);
        check({tag, "_dout"},       dout,       0);
    endtask

    // Start training (by raising train, or by releasing reset with train held) with the
    // frame lane k slips away from alignment, and wait for lock.
    task automatic run_lock(input int k, input bit via_reset, input string tag);
        int n;
        int lat;
        pulse_base     = pulse_cnt;
        frame_start    = rotr(PAT, k);
        frame_force_en = 1'b0;
        if (via_reset) reset = 1'b0;
        else train = 1'b1;
        lat = 2 + MATCH_CNT + k * (SLIP_WAIT + 2);
        n   = 0;
        while (locked !== 1'b1 && n < lat + 20) begin
            cycle();
            n++;
        end
        check({tag, "_lock_latency"}, n, lat);
        check({tag, "_pulses"},       pulse_cnt - pulse_base, k);
        check({tag, "_slip_cnt"},     slip_cnt, k);
        check({tag, "_dout_valid"},   dout_valid, 1);
    endtask

    task automatic drop_train(input int k, input string tag);
        train = 1'b0;
        cycle();
        check({tag, "_idle_locked"},     locked,     0);
        check({tag, "_idle_dout_valid"}, dout_valid, 0);
        repeat (6) cycle();
        check({tag, "_idle_slip_hold"},  slip_cnt,   k);
        check({tag, "_idle_align_err"},  align_err,  0);
    endtask

    // Scoreboard monitor and bitslip spacing watcher.
    initial begin
        forever begin
            @(posedge clkdiv);
            mon_cyc++;
            mon_have = 1'b0;
            if (!reset && exp_q.size() > 0) begin
                mon_exp  = exp_q.pop_front();
                mon_have = 1'b1;
            end
            @(negedge clkdiv);
            if (mon_have && !reset) check("dout", dout, mon_exp);
            if (reset) begin
                mon_last = -1;
            end else if (bitslip) begin
                if (mon_last >= 0) begin
                    check("bitslip_gap",
                          (mon_cyc - mon_last >= SLIP_WAIT + 2) ? SLIP_WAIT + 2
                                                                : mon_cyc - mon_last,
                          SLIP_WAIT + 2);
                end
                pulse_cnt++;
                mon_last = mon_cyc;
            end
        end
    end

    initial begin
        int n;
        int p;
        int k;
        logic [DW-1:0] bad;

        // Reset state
        repeat (3) cycle();
        check_cleared("reset");
        reset = 1'b0;
        repeat (2) cycle();

        // 1: frame already aligned
        run_lock(0, 1'b0, "t1");
        drop_train(0, "t1");

        // 2: frame rotated away by k slips
        for (int i = 0; i < 3; i++) begin
            k = (i == 0) ? 3 : int'($urandom_range(1, 7));
            run_lock(k, 1'b0, "t2");
            if (i < 2) drop_train(k, "t2");
        end

        // 4: loss-of-frame monitor
        bad = DW'($urandom);
        if (bad == PAT) bad = ~PAT;
        frame_force    = PAT;
        frame_force_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame_force = (i == 3) ? PAT : bad;
            cycle();
            check("t4_hold", locked, 1);
        end
        frame_force = PAT;
        repeat (2) cycle();
        check("t4_hold_after", locked, 1);
        frame_force = bad;
        repeat (4) cycle();
        check("t4_slip_cleared", slip_cnt, 0);
        cycle();
        check("t4_locked_drop",  locked,     0);
        check("t4_valid_drop",   dout_valid, 0);
        check("t4_retrain_slip", bitslip,    1);
        check("t4_retrain_cnt",  slip_cnt,   1);
        train = 1'b0;
        repeat (6) cycle();

        // 3: frame never matches
        frame_force = '0;
        pulse_base  = pulse_cnt;
        train       = 1'b1;
        n = 0;
        while (align_err !== 1'b1 && n < 3 + (2*DW - 1) * (SLIP_WAIT + 2) + 20) begin
            cycle();
            n++;
        end
        check("t3_err_latency", n, 3 + (2*DW - 1) * (SLIP_WAIT + 2));
        check("t3_slip_cnt",    slip_cnt, 2*DW);
        check("t3_pulses",      pulse_cnt - pulse_base, 2*DW);
        check("t3_locked",      locked, 0);
        p = pulse_cnt;
        repeat (20) cycle();
        check("t3_no_more_slips", pulse_cnt, p);
        check("t3_err_stays",     align_err, 1);
        train = 1'b0;
        repeat (6) cycle();
        check("t3_idle_err_hold",  align_err, 1);
        check("t3_idle_slip_hold", slip_cnt,  2*DW);
        train = 1'b1;
        cycle();
        check("t3_err_cleared",  align_err, 0);
        check("t3_slip_cleared", slip_cnt,  0);
        train = 1'b0;
        repeat (6) cycle();

        // 5: polarity and interleave
        lane_fixed = 1'b1;
        lane_a = '1;
        lane_b = '0;
        inv_a  = '0;
        inv_b  = '0;
        cycle();
        check("t5_ch0_plain", dout[15:0],  16'hAAAA);
        check("t5_ch1_plain", dout[31:16], 16'hAAAA);
        inv_b = '1;
        cycle();
        check("t5_ch0_invb", dout[15:0],  16'hFFFF);
        check("t5_ch1_invb", dout[31:16], 16'hFFFF);
        inv_a = '1;
        inv_b = '0;
        cycle();
        check("t5_ch0_inva", dout[15:0],  16'h0000);
        inv_a = 2'b01;
        cycle();
        check("t5_ch0_mixed", dout[15:0],  16'h0000);
        check("t5_ch1_mixed", dout[31:16], 16'hAAAA);
        lane_fixed = 1'b0;

        // 6a: reset during SETTLE, then restart from CHECK on release
        frame_force_en = 1'b0;
        pulse_base     = pulse_cnt;
        frame_start    = rotr(PAT, 3);
        train          = 1'b1;
        n = 0;
        while (bitslip !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        check("t6a_slip_seen", bitslip, 1);
        cycle();
        check("t6a_settle_slip", slip_cnt, 1);
        reset = 1'b1;
        #1;
        check_cleared("t6a");
        exp_q.delete();
        repeat (2) cycle();
        run_lock(2, 1'b1, "t6a_restart");

        // 6b: reset during LOCKED
        repeat (3) cycle();
        reset = 1'b1;
        #1;
        check_cleared("t6b");
        exp_q.delete();
        repeat (2) cycle();
        run_lock(0, 1'b1, "t6b_restart");

        // 6c: reset truncates a bitslip pulse
        reset = 1'b1;
        #1;
        exp_q.delete();
        repeat (2) cycle();
        pulse_base  = pulse_cnt;
        frame_start = rotr(PAT, 1);
        reset       = 1'b0;
        n = 0;
        while (bitslip !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        check("t6c_slip_seen", bitslip, 1);
        reset = 1'b1;
        #1;
        check("t6c_truncated", bitslip, 0);
        exp_q.delete();

        train = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
